imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder on the far side of the core's fetch interface.
- The core drives an 8-bit PC and a one-cycle fetch strobe, then samples the instruction byte on the following cycle. This block answers that strobe from a small flop-based program memory.
- A byte-stream load port fills the memory before or between runs.
- A watchdog flags a core that has stopped fetching; this is how a stall on opcode 42 is detected.

Parameters:
- DEPTH, 16, number of program bytes held (power of two, 2..256).
- FILL, 8'h00, byte returned for out-of-range addresses and for any fetch during LOAD.
- TIMEOUT, 64, idle cycles without a fetch (in SERVE) before hung asserts; 1..65535.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- fetch  in  1  fetch strobe from the core; one cycle high, addr valid that cycle.
- addr  in  8  fetch address (core PC).
- rdata  out  8  instruction byte to the core; registered.
- ld_start  in  1  pulse: enter LOAD and clear the write pointer.
- ld_valid  in  1  load byte valid.
- ld_data  in  8  load byte.
- ld_last  in  1  qualifies ld_data as the final byte of the image.
- ld_ready  out  1  high exactly while in LOAD.
- loading  out  1  high while in LOAD (same as ld_ready; separate port for status readout).
- fetch_cnt  out  8  number of fetches served in SERVE; wraps at 255 -> 0.
- hung  out  1  watchdog flag; sticky.

Behaviour:
- Reset values (rst=1 at a clock edge):
  - state = SERVE; all mem entries = 8'h00; wptr = 0.
  - rdata = FILL, fetch_cnt = 0, wd_cnt = 0, hung = 0, ld_ready = 0.
- Reset mid-load abandons the load; bytes already written are also cleared to 0.
- States: SERVE, LOAD.
- SERVE -> LOAD: on ld_start=1.
- LOAD -> SERVE, either:
  - an accepted byte (ld_valid & ld_ready) with ld_last=1, or
  - an accepted byte written at wptr = DEPTH-1.
- ld_start while already in LOAD: wptr <= 0 and state stays LOAD. Bytes already written are kept.
- Load write:
  - Each accepted byte does mem[wptr] <= ld_data and wptr <= wptr+1.
  - wptr is clog2(DEPTH) bits wide and never wraps, because the write at DEPTH-1 exits LOAD.
  - ld_valid outside LOAD is ignored; nothing is written.
- Fetch in SERVE (fetch=1):
  - Next cycle, rdata = mem[addr] if addr < DEPTH, else FILL.
  - fetch_cnt increments; wd_cnt <= 0; hung <= 0.
  - Latency is exactly 1 cycle: the value is visible in the cycle after the strobe, which is when the core samples it.
- Fetch in LOAD (fetch=1): rdata <= FILL. Not counted; the watchdog is unaffected.
- No fetch: rdata holds its last value.
- Simultaneous ld_start and fetch in SERVE:
  - The ld_start transition takes effect.
  - The fetch is treated as a LOAD-state fetch: rdata <= FILL, not counted.
- Read-during-write: a LOAD-state fetch never reads mem, so no bypass path is needed.
- Watchdog:
  - Active only in SERVE. In SERVE with fetch=0, wd_cnt increments and saturates at TIMEOUT.
  - hung <= 1 on the cycle wd_cnt reaches TIMEOUT, i.e. TIMEOUT idle cycles after the last fetch or entry to SERVE.
  - hung clears on the next SERVE fetch, on ld_start, or on rst.
  - Entering LOAD clears wd_cnt; wd_cnt is held at 0 throughout LOAD.

Decomposition:
- Shared package core_if_pkg holds:
  - state encoding ST_SERVE / ST_LOAD;
  - constant OP_HALT = 8'd42 (the core's stall opcode);
  - FETCH_LATENCY = 1.
- Natural sub-module: imem_watchdog, holding wd_cnt and hung. It takes clk, rst, enable (= SERVE), kick (= served fetch) and clear (= ld_start).
- The memory array, load FSM and fetch path stay in the top module.

Test Plan:
- Reset then fetch addr=3 -> rdata=8'h00 the next cycle; fetch_cnt=1; hung=0.
- Load image, then fetch:
  - Stimulus: ld_start; load bytes 11,22,33 with ld_last on 33; then fetch addr=0,1,2,3 three cycles apart.
  - Expected: ld_ready drops the cycle after 33 is accepted; rdata = 8'h11, 8'h22, 8'h33, 8'h00; fetch_cnt = 4.
- Fill to capacity without ld_last:
  - Stimulus: load 16 bytes 0x10..0x1F; a 17th ld_valid is presented.
  - Expected: LOAD exits after byte 16; the 17th is ignored; fetch addr=15 -> 0x1F; fetch addr=200 -> FILL.
- Fetch and restart during LOAD:
  - Stimulus: fetch during LOAD; then ld_start mid-load after writing 0xAA at addr 0; then write 0xBB with ld_last.
  - Expected: rdata=FILL and fetch_cnt unchanged during LOAD; mem[0]=0xBB.
- Watchdog on stall, TIMEOUT=64:
  - Stimulus: load OP_HALT at addr 0; core-style fetch of addr 0 then no further fetches.
  - Expected: hung rises exactly 64 cycles after the fetch strobe; the next fetch clears it the following cycle.
- Mid-load reset:
  - Stimulus: rst asserted after 2 accepted load bytes.
  - Expected: state=SERVE, loading=0; a fetch of addr 0 returns 0x00; fetch_cnt=1.

Source files
------------

// File: rtl/core_if_pkg.sv
// -----------------------------------------------------------------------------
// core_if_pkg
// Shared definitions for the core's fetch interface and the instruction-memory
// responder: responder state encoding, the core's stall opcode, and the fetch
// latency the core assumes (strobe in cycle N, data sampled in cycle N+1).
// -----------------------------------------------------------------------------
package core_if_pkg;

  typedef enum logic {
    ST_SERVE = 1'b0,
    ST_LOAD  = 1'b1
  } state_e;

  localparam logic [7:0] OP_HALT       = 8'd42;
  localparam int         FETCH_LATENCY = 1;

endpackage

// File: rtl/imem_responder_if.sv
// -----------------------------------------------------------------------------
// imem_responder_if
// Bundles the fetch bus, the byte-stream load port and the status outputs of
// the instruction-memory responder.
//   master : the core / loader side (drives fetch, addr, ld_*)
//   slave  : the responder (drives rdata, ld_ready, loading, fetch_cnt, hung)
// -----------------------------------------------------------------------------
interface imem_responder_if;

  logic       fetch;
  logic [7:0] addr;
  logic [7:0] rdata;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       loading;
  logic [7:0] fetch_cnt;
  logic       hung;

  modport master (
    output fetch, addr, ld_start, ld_valid, ld_data, ld_last,
    input  rdata, ld_ready, loading, fetch_cnt, hung
  );

  modport slave (
    input  fetch, addr, ld_start, ld_valid, ld_data, ld_last,
    output rdata, ld_ready, loading, fetch_cnt, hung
  );

endinterface

// File: rtl/imem_watchdog.sv
// -----------------------------------------------------------------------------
// imem_watchdog
// Counts idle cycles while the responder is serving; raises a sticky hung
// flag once TIMEOUT consecutive cycles pass without a served fetch.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   i_enable   counting allowed (responder in SERVE); counter held at 0 otherwise
//   i_kick     a fetch was served this cycle; restarts the count, clears hung
//   i_clear    load start; restarts the count, clears hung
//   o_hung     sticky watchdog flag
// -----------------------------------------------------------------------------
module imem_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_kick,
  input  logic i_clear,
  output logic o_hung
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  logic [15:0] r_wd_cnt;
  logic        r_hung;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
      r_hung   <= 1'b0;
    end else if (i_clear) begin
      r_wd_cnt <= '0;
      r_hung   <= 1'b0;
    end else if (!i_enable) begin
      r_wd_cnt <= '0;
    end else if (i_kick) begin
      r_wd_cnt <= '0;
      r_hung   <= 1'b0;
    end else if (r_wd_cnt != LIMIT) begin
      // Saturating count; hung is set on the same edge the count lands on LIMIT.
      r_wd_cnt <= r_wd_cnt + 16'd1;
      if (r_wd_cnt == LIMIT - 16'd1) begin
        r_hung <= 1'b1;
      end
    end
  end

  assign o_hung = r_hung;

endmodule

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Answers the core's one-cycle fetch strobe from a small flop-based program
// memory with a registered byte one cycle later. A byte-stream load port fills
// the memory; a watchdog flags a core that has stopped fetching.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        imem_responder_if.slave: fetch/addr/rdata, ld_start/ld_valid/
//              ld_data/ld_last/ld_ready, loading, fetch_cnt, hung
// -----------------------------------------------------------------------------
module imem_responder
  import core_if_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter logic [7:0] FILL    = 8'h00,
  parameter int         TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  imem_responder_if.slave   bus
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [7:0]    r_rdata;
  logic [7:0]    r_fetch_cnt;

  logic          w_in_load;
  logic          w_accept;
  logic          w_write;
  logic          w_serve_fetch;
  logic          w_in_range;
  logic [7:0]    w_rd_byte;
  logic          w_hung;

  assign w_in_load = (r_state == ST_LOAD);
  assign w_accept  = w_in_load && bus.ld_valid;
  // A restart pulse in LOAD wins over a byte presented in the same cycle.
  assign w_write   = w_accept && !bus.ld_start;
  // A fetch coinciding with ld_start in SERVE is treated as a LOAD-state fetch.
  assign w_serve_fetch = bus.fetch && !w_in_load && !bus.ld_start;

  assign w_in_range = ({24'd0, bus.addr} < 32'(DEPTH));
  assign w_rd_byte  = w_in_range ? r_mem[bus.addr[AW-1:0]] : FILL;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SERVE: begin
        if (bus.ld_start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_write && (bus.ld_last || r_wptr == LAST_IDX)) w_state_nxt = ST_SERVE;
      end
      default: w_state_nxt = ST_SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SERVE;
      r_wptr      <= '0;
      r_rdata     <= FILL;
      r_fetch_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      r_state <= w_state_nxt;

      if (bus.ld_start) begin
        r_wptr <= '0;
      end else if (w_write) begin
        r_mem[r_wptr] <= bus.ld_data;
        r_wptr        <= r_wptr + AW'(1);
      end

      if (bus.fetch) begin
        r_rdata <= w_serve_fetch ? w_rd_byte : FILL;
      end

      if (w_serve_fetch) begin
        r_fetch_cnt <= r_fetch_cnt + 8'd1;
      end
    end
  end

  imem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_enable (!w_in_load),
    .i_kick   (w_serve_fetch),
    .i_clear  (bus.ld_start),
    .o_hung   (w_hung)
  );

  assign bus.rdata     = r_rdata;
  assign bus.ld_ready  = w_in_load;
  assign bus.loading   = w_in_load;
  assign bus.fetch_cnt = r_fetch_cnt;
  assign bus.hung      = w_hung;

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
// Directed scenarios with literal expectations, then randomized traffic, all
// checked every cycle against a behavioural model of the responder.
// -----------------------------------------------------------------------------
module tb_imem_responder;
  import core_if_pkg::*;

  localparam int         DEPTH   = 16;
  localparam logic [7:0] FILL    = 8'h00;
  localparam int         TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_responder_if bus();

  imem_responder #(
    .DEPTH   (DEPTH),
    .FILL    (FILL),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         model_on = 0;
  logic [7:0] m_mem [DEPTH];
  bit         m_loading;
  int         m_wptr;
  logic [7:0] m_rdata;
  int         m_cnt;
  int         m_idle;
  bit         m_hung;
  bit         m_served;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_loading = 0; m_wptr = 0; m_rdata = FILL;
      m_cnt = 0; m_idle = 0; m_hung = 0;
      model_on = 1;
    end else begin
      m_served = bus.fetch && !m_loading && !bus.ld_start;
      if (bus.fetch)
        m_rdata = (m_served && int'(bus.addr) < DEPTH) ? m_mem[int'(bus.addr)] : FILL;
      if (m_served) begin
        m_cnt  = (m_cnt + 1) % 256;
        m_idle = 0;
        m_hung = 0;
      end
      if (bus.ld_start) begin
        m_loading = 1; m_wptr = 0; m_idle = 0; m_hung = 0;
      end else if (m_loading) begin
        if (bus.ld_valid) begin
          m_mem[m_wptr] = bus.ld_data;
          if (bus.ld_last || m_wptr == DEPTH - 1) m_loading = 0;
          m_wptr++;
        end
      end else if (!m_served) begin
        if (m_idle < TIMEOUT) m_idle++;
        if (m_idle == TIMEOUT) m_hung = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("rdata",     int'(bus.rdata),     int'(m_rdata));
      chk("ld_ready",  int'(bus.ld_ready),  int'(m_loading));
      chk("loading",   int'(bus.loading),   int'(m_loading));
      chk("fetch_cnt", int'(bus.fetch_cnt), m_cnt);
      chk("hung",      int'(bus.hung),      int'(m_hung));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch = 0; bus.ld_start = 0; bus.ld_valid = 0; bus.ld_last = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic fetch_at(input logic [7:0] a);
    bus.fetch = 1; bus.addr = a;
    tick();
    bus.fetch = 0;
  endtask

  task automatic ld_begin();
    bus.ld_start = 1;
    tick();
    bus.ld_start = 0;
  endtask

  task automatic ld_byte(input logic [7:0] d, input bit last);
    bus.ld_valid = 1; bus.ld_data = d; bus.ld_last = last;
    tick();
    bus.ld_valid = 0; bus.ld_last = 0;
  endtask

  logic [7:0] exp_img [4];
  int         n_wait;
  int         pf;

  initial begin
    bus.addr = 8'h00; bus.ld_data = 8'h00;
    idle_inputs();

    // Reset values, then a fetch from the cleared memory.
    do_reset();
    chk("rst_rdata", int'(bus.rdata), 8'h00);
    chk("rst_fetch_cnt", int'(bus.fetch_cnt), 0);
    chk("rst_hung", int'(bus.hung), 0);
    chk("rst_ld_ready", int'(bus.ld_ready), 0);
    fetch_at(8'd3);
    chk("f3_rdata", int'(bus.rdata), 8'h00);
    chk("f3_cnt", int'(bus.fetch_cnt), 1);
    chk("f3_hung", int'(bus.hung), 0);

    // Load a short image terminated by ld_last, then fetch it back.
    do_reset();
    ld_begin();
    chk("ld_ready_up", int'(bus.ld_ready), 1);
    ld_byte(8'h11, 0);
    ld_byte(8'h22, 0);
    ld_byte(8'h33, 1);
    chk("ld_ready_drop", int'(bus.ld_ready), 0);
    exp_img[0] = 8'h11; exp_img[1] = 8'h22; exp_img[2] = 8'h33; exp_img[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      fetch_at(8'(i));
      chk("img_rdata", int'(bus.rdata), int'(exp_img[i]));
      tick();
      tick();
    end
    chk("img_cnt", int'(bus.fetch_cnt), 4);

    // Fill to capacity without ld_last; extra byte is ignored.
    do_reset();
    ld_begin();
    for (int i = 0; i < DEPTH; i++) ld_byte(8'(8'h10 + i), 0);
    chk("full_exit", int'(bus.loading), 0);
    ld_byte(8'hEE, 0);
    chk("full_17th_ignored", int'(bus.loading), 0);
    fetch_at(8'd15);
    chk("full_a15", int'(bus.rdata), 8'h1F);
    fetch_at(8'd200);
    chk("full_a200", int'(bus.rdata), int'(FILL));
    fetch_at(8'd0);
    chk("full_a0", int'(bus.rdata), 8'h10);
    fetch_at(8'd15);
    chk("full_cnt", int'(bus.fetch_cnt), 4);

    // Fetch during LOAD returns FILL uncounted; restart keeps earlier bytes.
    ld_begin();
    fetch_at(8'd0);
    chk("load_fetch_rdata", int'(bus.rdata), int'(FILL));
    chk("load_fetch_cnt", int'(bus.fetch_cnt), 4);
    ld_byte(8'hAA, 0);
    ld_begin();
    ld_byte(8'hBB, 1);
    fetch_at(8'd0);
    chk("restart_a0", int'(bus.rdata), 8'hBB);
    fetch_at(8'd1);
    chk("restart_a1_kept", int'(bus.rdata), 8'h11);
    chk("restart_cnt", int'(bus.fetch_cnt), 6);

    // Watchdog: core fetches OP_HALT and stops fetching.
    do_reset();
    ld_begin();
    ld_byte(OP_HALT, 1);
    fetch_at(8'd0);
    chk("halt_rdata", int'(bus.rdata), 42);
    n_wait = 0;
    while (!bus.hung && n_wait < 200) begin
      tick();
      n_wait++;
    end
    chk("wd_latency", n_wait, TIMEOUT);
    fetch_at(8'd0);
    chk("wd_clear", int'(bus.hung), 0);

    // Reset in the middle of a load.
    do_reset();
    ld_begin();
    ld_byte(8'h55, 0);
    ld_byte(8'h66, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_loading", int'(bus.loading), 0);
    fetch_at(8'd0);
    chk("midrst_a0", int'(bus.rdata), 8'h00);
    chk("midrst_cnt", int'(bus.fetch_cnt), 1);

    // Randomized traffic; every third segment is fetch-free to exercise the watchdog.
    do_reset();
    for (int seg = 0; seg < 12; seg++) begin
      pf = (seg % 3 == 2) ? 0 : int'($urandom_range(5, 70));
      for (int c = 0; c < 180; c++) begin
        rst          = ($urandom_range(0, 599) == 0);
        bus.ld_start = ($urandom_range(0, 99) < 2);
        bus.fetch    = (int'($urandom_range(0, 99)) < pf);
        bus.addr     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 19));
        bus.ld_valid = ($urandom_range(0, 1) == 1);
        bus.ld_last  = ($urandom_range(0, 99) < 12);
        bus.ld_data  = 8'($urandom_range(0, 255));
        tick();
      end
      rst = 0;
    end

    idle_inputs();
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
